// File: rtl/vram_read_arbiter_if.sv
// rtl/vram_read_arbiter_if.sv - requester and VRAM signal bundle for vram_read_arbiter
interface vram_read_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  disp_req;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic                  disp_grant;
    logic                  disp_valid;
    logic [DATA_WIDTH-1:0] disp_data;

    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_grant;
    logic                  cpu_valid;
    logic [DATA_WIDTH-1:0] cpu_data;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_addr, mem_data,
        output disp_grant, disp_valid, disp_data,
        output cpu_grant, cpu_valid, cpu_data, mem_addr
    );

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_addr, mem_data,
        input  disp_grant, disp_valid, disp_data,
        input  cpu_grant, cpu_valid, cpu_data, mem_addr
    );
endinterface

// File: rtl/vram_read_arbiter.sv
// rtl/vram_read_arbiter.sv - display/CPU arbiter for the VRAM read port
// Optional display stall counter enabled by VRAM_ARB_STATS_EN.
module vram_read_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_LATENCY  = 1,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    vram_read_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic               stats_clear,
    output logic [15:0]        disp_stall_count
`endif
);
    localparam int         STAGES   = MEM_LATENCY + 1;
    localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);

    logic                  w_cpu_force;
    logic                  w_cpu_win;
    logic                  w_disp_win;
    logic                  w_any_win;
    logic [3:0]            r_starve;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [STAGES-1:0]     r_tag_vld;
    logic [STAGES-1:0]     r_tag_cpu;
    logic [DATA_WIDTH-1:0] r_disp_data;
    logic [DATA_WIDTH-1:0] r_cpu_data;

    // Display has priority unless the CPU has waited CPU_MAX_WAIT cycles.
    always_comb begin
        w_cpu_force = bus.cpu_req && (r_starve == WAIT_MAX);
        w_cpu_win   = bus.cpu_req && (w_cpu_force || !bus.disp_req);
        w_disp_win  = bus.disp_req && !w_cpu_win;
        w_any_win   = w_cpu_win || w_disp_win;
    end

    assign bus.disp_grant = w_disp_win && reset_n;
    assign bus.cpu_grant  = w_cpu_win && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr <= '0;
        end else if (w_disp_win) begin
            r_mem_addr <= bus.disp_addr;
        end else if (w_cpu_win) begin
            r_mem_addr <= bus.cpu_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= 4'd0;
        end else if (!bus.cpu_req || w_cpu_win) begin
            r_starve <= 4'd0;
        end else if (r_starve != WAIT_MAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Stage k holds {valid, owner} for the read granted k+1 cycles ago.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld <= '0;
            r_tag_cpu <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[STAGES-2:0], w_any_win};
            r_tag_cpu <= {r_tag_cpu[STAGES-2:0], w_cpu_win};
        end
    end

    // Capture on the same edge that moves the tag into the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_data <= '0;
            r_cpu_data  <= '0;
        end else if (r_tag_vld[STAGES-2]) begin
            if (r_tag_cpu[STAGES-2]) begin
                r_cpu_data <= bus.mem_data;
            end else begin
                r_disp_data <= bus.mem_data;
            end
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.disp_valid = r_tag_vld[STAGES-1] && !r_tag_cpu[STAGES-1];
    assign bus.cpu_valid  = r_tag_vld[STAGES-1] && r_tag_cpu[STAGES-1];
    assign bus.disp_data  = r_disp_data;
    assign bus.cpu_data   = r_cpu_data;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= 16'd0;
        end else if (stats_clear) begin
            r_stall_count <= 16'd0;
        end else if (bus.disp_req && !w_disp_win && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign disp_stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_vram_read_arbiter.sv
// tb/tb_vram_read_arbiter.sv - self-checking bench for vram_read_arbiter
module tb_vram_read_arbiter;
    localparam int ADDR_WIDTH   = 15;
    localparam int DATA_WIDTH   = 8;
    localparam int MEM_LATENCY  = 1;
    localparam int CPU_MAX_WAIT = 4;

    typedef struct {
        int                    due;
        bit                    cpu;
        logic [DATA_WIDTH-1:0] data;
    } ret_t;

    logic clk;
    logic reset_n;
    logic [DATA_WIDTH-1:0] vram [0:(1<<ADDR_WIDTH)-1];

    vram_read_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus_if ();

`ifdef VRAM_ARB_STATS_EN
    logic        stats_clear;
    logic [15:0] disp_stall_count;
    int          m_stall;
`endif

    vram_read_arbiter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_LATENCY (MEM_LATENCY),
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus_if)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stats_clear     (stats_clear),
        .disp_stall_count(disp_stall_count)
`endif
    );

    // Registered-address VRAM: with MEM_LATENCY=1 the byte follows mem_addr directly.
    assign bus_if.mem_data = vram[bus_if.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_wait = 0;
    logic [ADDR_WIDTH-1:0] m_mem_addr = '0;
    logic [DATA_WIDTH-1:0] m_disp_data = '0;
    logic [DATA_WIDTH-1:0] m_cpu_data = '0;
    ret_t pend[$];
    logic g_disp = 1'b0;
    logic g_cpu = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_grant"}, 32'(bus_if.disp_grant), 32'd0);
        chk({tag, "_cpu_grant"},  32'(bus_if.cpu_grant),  32'd0);
        chk({tag, "_disp_valid"}, 32'(bus_if.disp_valid), 32'd0);
        chk({tag, "_cpu_valid"},  32'(bus_if.cpu_valid),  32'd0);
        chk({tag, "_disp_data"},  32'(bus_if.disp_data),  32'd0);
        chk({tag, "_cpu_data"},   32'(bus_if.cpu_data),   32'd0);
        chk({tag, "_mem_addr"},   32'(bus_if.mem_addr),   32'd0);
`ifdef VRAM_ARB_STATS_EN
        chk({tag, "_stall_cnt"},  32'(disp_stall_count),  32'd0);
`endif
    endtask

    task automatic model_reset();
        pend.delete();
        m_wait      = 0;
        m_mem_addr  = '0;
        m_disp_data = '0;
        m_cpu_data  = '0;
        g_disp      = 1'b0;
        g_cpu       = 1'b0;
`ifdef VRAM_ARB_STATS_EN
        m_stall     = 0;
`endif
    endtask

    // One clock cycle: check the DUT mid-cycle against the model, then advance the model.
    task automatic tick();
        logic e_cpu, e_disp, ev_d, ev_c;
        @(negedge clk);
        e_cpu  = bus_if.cpu_req && ((m_wait == CPU_MAX_WAIT) || !bus_if.disp_req);
        e_disp = bus_if.disp_req && !e_cpu;
        ev_d = 1'b0;
        ev_c = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].cpu) begin
                ev_c = 1'b1;
                m_cpu_data = pend[0].data;
            end else begin
                ev_d = 1'b1;
                m_disp_data = pend[0].data;
            end
            void'(pend.pop_front());
        end
        chk("disp_grant", 32'(bus_if.disp_grant), 32'(e_disp));
        chk("cpu_grant",  32'(bus_if.cpu_grant),  32'(e_cpu));
        chk("mem_addr",   32'(bus_if.mem_addr),   32'(m_mem_addr));
        chk("disp_valid", 32'(bus_if.disp_valid), 32'(ev_d));
        chk("cpu_valid",  32'(bus_if.cpu_valid),  32'(ev_c));
        chk("disp_data",  32'(bus_if.disp_data),  32'(m_disp_data));
        chk("cpu_data",   32'(bus_if.cpu_data),   32'(m_cpu_data));
`ifdef VRAM_ARB_STATS_EN
        chk("stall_count", 32'(disp_stall_count), 32'(m_stall));
        if (stats_clear) m_stall = 0;
        else if (bus_if.disp_req && !e_disp && m_stall < 16'hFFFF) m_stall++;
`endif
        g_disp = e_disp;
        g_cpu  = e_cpu;
        if (e_disp) begin
            pend.push_back('{cyc + 1 + MEM_LATENCY, 1'b0, vram[bus_if.disp_addr]});
            m_mem_addr = bus_if.disp_addr;
        end else if (e_cpu) begin
            pend.push_back('{cyc + 1 + MEM_LATENCY, 1'b1, vram[bus_if.cpu_addr]});
            m_mem_addr = bus_if.cpu_addr;
        end
        if (bus_if.cpu_req && !e_cpu) begin
            if (m_wait < CPU_MAX_WAIT) m_wait++;
        end else begin
            m_wait = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int ngrant, nval, nbad;
        for (int a = 0; a < (1 << ADDR_WIDTH); a++) vram[a] = 8'($urandom);
        vram[15'h0123] = 8'hA5;
        vram[15'h0001] = 8'h11;
        vram[15'h0002] = 8'h22;

        reset_n          = 1'b0;
        bus_if.disp_req  = 1'b0;
        bus_if.disp_addr = '0;
        bus_if.cpu_req   = 1'b0;
        bus_if.cpu_addr  = '0;
`ifdef VRAM_ARB_STATS_EN
        stats_clear      = 1'b0;
`endif
        model_reset();
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Lone display read of 0x0123.
        bus_if.disp_req  = 1'b1;
        bus_if.disp_addr = 15'h0123;
        tick();
        chk("lone_grant", 32'(g_disp), 32'd1);
        bus_if.disp_req = 1'b0;
        chk("lone_mem_addr_c1", 32'(bus_if.mem_addr), 32'h0123);
        chk("lone_valid_c1", 32'(bus_if.disp_valid), 32'd0);
        tick();
        chk("lone_valid_c2", 32'(bus_if.disp_valid), 32'd1);
        chk("lone_data_c2", 32'(bus_if.disp_data), 32'hA5);
        tick();
        chk("lone_valid_c3", 32'(bus_if.disp_valid), 32'd0);
        repeat (2) tick();

        // Streaming display 0..7.
        ngrant = 0;
        nval = 0;
        nbad = 0;
        for (int i = 0; i < 8; i++) begin
            bus_if.disp_req  = 1'b1;
            bus_if.disp_addr = 15'(i);
            tick();
            ngrant += int'(g_disp);
            nval   += int'(bus_if.disp_valid);
            nbad   += int'(bus_if.cpu_valid);
        end
        bus_if.disp_req = 1'b0;
        repeat (3) begin
            tick();
            nval += int'(bus_if.disp_valid);
            nbad += int'(bus_if.cpu_valid);
        end
        chk("stream_grants", 32'(ngrant), 32'd8);
        chk("stream_valids", 32'(nval), 32'd8);
        chk("stream_cpu_valid", 32'(nbad), 32'd0);

        // Interleaved ownership.
        bus_if.disp_req  = 1'b1;
        bus_if.disp_addr = 15'h0001;
        tick();
        bus_if.disp_req = 1'b0;
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_addr = 15'h0002;
        tick();
        chk("inter_cpu_grant", 32'(g_cpu), 32'd1);
        bus_if.cpu_req = 1'b0;
        chk("inter_disp_valid_c2", 32'(bus_if.disp_valid), 32'd1);
        chk("inter_disp_data_c2", 32'(bus_if.disp_data), 32'h11);
        tick();
        chk("inter_cpu_valid_c3", 32'(bus_if.cpu_valid), 32'd1);
        chk("inter_cpu_data_c3", 32'(bus_if.cpu_data), 32'h22);
        chk("inter_disp_hold_c3", 32'(bus_if.disp_data), 32'h11);
        repeat (2) tick();

        // Reset while a CPU read is in flight.
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_addr = 15'h0010;
        tick();
        chk("rst_cpu_grant", 32'(g_cpu), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        bus_if.cpu_req = 1'b0;
        reset_n = 1'b1;
        cyc++;
        chk("rst_no_cpu_valid_rel", 32'(bus_if.cpu_valid), 32'd0);
        repeat (4) begin
            tick();
            chk("rst_no_cpu_valid", 32'(bus_if.cpu_valid), 32'd0);
        end

        // Starvation: both held, CPU forced in cycles 4 and 9.
`ifdef VRAM_ARB_STATS_EN
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
`endif
        bus_if.disp_addr = 15'h0100;
        bus_if.cpu_addr  = 15'h0200;
        for (int k = 0; k < 10; k++) begin
            bus_if.disp_req = 1'b1;
            bus_if.cpu_req  = 1'b1;
            tick();
            chk($sformatf("starve_cpu_c%0d", k), 32'(g_cpu), 32'(k == 4 || k == 9));
            chk($sformatf("starve_disp_c%0d", k), 32'(g_disp), 32'(!(k == 4 || k == 9)));
        end
        bus_if.cpu_req = 1'b0;
`ifdef VRAM_ARB_STATS_EN
        chk("stats_after_starve", 32'(disp_stall_count), 32'd2);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("stats_cleared", 32'(disp_stall_count), 32'd0);
`else
        tick();
`endif
        chk("starve_disp_after", 32'(g_disp), 32'd1);
        bus_if.disp_req = 1'b0;
        repeat (3) tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if (!bus_if.disp_req || g_disp) begin
                bus_if.disp_req  = ($urandom_range(0, 3) != 0);
                bus_if.disp_addr = 15'($urandom);
            end
            if (!bus_if.cpu_req || g_cpu) begin
                bus_if.cpu_req  = 1'($urandom_range(0, 1));
                bus_if.cpu_addr = 15'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                bus_if.cpu_req = 1'b0;
            end
`ifdef VRAM_ARB_STATS_EN
            stats_clear = ($urandom_range(0, 31) == 0);
`endif
            tick();
        end
`ifdef VRAM_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        bus_if.cpu_req = 1'b0;
        if (bus_if.disp_req && !g_disp) tick();
        bus_if.disp_req = 1'b0;
        repeat (MEM_LATENCY + 3) tick();
        chk("drain_empty", 32'(pend.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
